// File: rtl/uc_secuenciador_pkg.sv
// Shared types and constants for the microcontroller control unit.
// State encoding, opcode map and the control-line bundle.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED,
        ST_RESTART,
        ST_FAULT
    } state_t;

    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_NOP  = 6'b010011;
    localparam logic [5:0] OP_HALT = 6'b011111;

    localparam logic [3:0] PFX_LI   = 4'b0000;
    localparam logic [3:0] PFX_ADDI = 4'b0001;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_DEF = '{
        s_inc:  1'b1,
        s_inm:  1'b0,
        we3:    1'b0,
        wez:    1'b0,
        alu_op: ALU_PASSB
    };

endpackage

// File: rtl/uc_secuenciador_if.sv
// Control bus between the sequencer and the single-cycle datapath.
// master = control unit, slave = datapath.
interface uc_secuenciador_if;

    logic [5:0] opcode;
    logic       zero;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] ALUOp;
    logic       dp_reset;

    modport master (
        input  opcode,
        input  zero,
        output s_inc,
        output s_inm,
        output we3,
        output wez,
        output ALUOp,
        output dp_reset
    );

    modport slave (
        output opcode,
        output zero,
        input  s_inc,
        input  s_inm,
        input  we3,
        input  wez,
        input  ALUOp,
        input  dp_reset
    );

endinterface

// File: rtl/uc_decoder.sv
// Combinational opcode decoder: control lines plus legality flags.
// Illegal opcodes leave every control at its safe default.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic       legal,
    output logic       is_halt
);

    always_comb begin
        ctrl    = CTRL_DEF;
        legal   = 1'b0;
        is_halt = 1'b0;
        unique case (1'b1)
            opcode[5]: begin
                ctrl.alu_op = opcode[4:2];
                ctrl.we3    = 1'b1;
                ctrl.wez    = 1'b1;
                legal       = 1'b1;
            end
            (opcode[5:2] == PFX_LI): begin
                ctrl.alu_op = ALU_PASSB;
                ctrl.s_inm  = 1'b1;
                ctrl.we3    = 1'b1;
                legal       = 1'b1;
            end
            (opcode[5:2] == PFX_ADDI): begin
                ctrl.alu_op = ALU_ADD;
                ctrl.s_inm  = 1'b1;
                ctrl.we3    = 1'b1;
                ctrl.wez    = 1'b1;
                legal       = 1'b1;
            end
            (opcode == OP_J): begin
                ctrl.s_inc = 1'b0;
                legal      = 1'b1;
            end
            (opcode == OP_JZ): begin
                ctrl.s_inc = ~zero;
                legal      = 1'b1;
            end
            (opcode == OP_JNZ): begin
                ctrl.s_inc = zero;
                legal      = 1'b1;
            end
            (opcode == OP_NOP): begin
                legal = 1'b1;
            end
            (opcode == OP_HALT): begin
                // PC self-loops on the HALT address
                ctrl.s_inc = 1'b0;
                legal      = 1'b1;
                is_halt    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/uc_secuenciador.sv
// Control unit and run sequencer: FSM, retired-instruction counter
// and gating of the decoded datapath controls.
module uc_secuenciador
    import uc_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    uc_secuenciador_if.master          dp,
    output logic                       busy,
    output logic                       done,
    output logic                       fault,
    output logic [15:0]                instr_count
);

    state_t state_q;
    state_t state_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;
    logic   legal;
    logic   is_halt;
    logic   start_ok;
    logic   retire;

    uc_decoder u_dec (
        .opcode  (dp.opcode),
        .zero    (dp.zero),
        .ctrl    (dec_ctrl),
        .legal   (legal),
        .is_halt (is_halt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (is_halt)     state_d = ST_HALTED;
                else if (!legal) state_d = ST_FAULT;
            end
            ST_HALTED:  if (start) state_d = ST_RESTART;
            ST_RESTART: state_d = ST_RUN;
            ST_FAULT:   if (start) state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign start_ok = start &&
        (state_q == ST_IDLE || state_q == ST_HALTED ||
         state_q == ST_FAULT);
    assign retire = (state_q == ST_RUN) && legal && !is_halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= 16'd0;
        end else if (start_ok) begin
            instr_count <= 16'd0;
        end else if (retire && instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    // Decoded controls only reach the datapath while running
    always_comb begin
        ctrl = CTRL_DEF;
        if (state_q == ST_RUN) begin
            ctrl = dec_ctrl;
        end else if (state_q == ST_HALTED) begin
            ctrl.s_inc = 1'b0;
        end
    end

    assign dp.s_inc    = ctrl.s_inc;
    assign dp.s_inm    = ctrl.s_inm;
    assign dp.we3      = ctrl.we3;
    assign dp.wez      = ctrl.wez;
    assign dp.ALUOp    = ctrl.alu_op;
    assign dp.dp_reset = reset ||
        state_q == ST_IDLE || state_q == ST_RESTART ||
        state_q == ST_FAULT;

    assign busy  = (state_q == ST_RUN) || (state_q == ST_RESTART);
    assign done  = (state_q == ST_HALTED);
    assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_uc_secuenciador.sv
// Bench for uc_secuenciador: scenario tasks checked against a
// behavioural model of run lifecycle, counter and opcode table.
module tb_uc_secuenciador;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_HALTED  = 2;
    localparam int M_RESTART = 3;
    localparam int M_FAULT   = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] instr_count;

    uc_secuenciador_if dp ();

    uc_secuenciador dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dp          (dp),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int m_st;
    int m_cnt;

    // {s_inc, s_inm, we3, wez, ALUOp[2:0]} from the opcode table
    function automatic logic [6:0] ref_ctrl(input int st,
                                            input logic [5:0] op,
                                            input logic z);
        int v;
        v = int'(op);
        if (st == M_HALTED) return 7'b0000000;
        if (st != M_RUN) return 7'b1000000;
        if (v >= 32) return {4'b1011, op[4:2]};
        if (v < 4) return 7'b1110000;
        if (v < 8) return 7'b1111010;
        if (v == 16) return 7'b0000000;
        if (v == 17) return {~z, 6'b000000};
        if (v == 18) return {z, 6'b000000};
        if (v == 19) return 7'b1000000;
        if (v == 31) return 7'b0000000;
        return 7'b1000000;
    endfunction

    function automatic bit ref_legal(input logic [5:0] op);
        int v;
        v = int'(op);
        return v >= 32 || v < 8 || (v >= 16 && v <= 19) || v == 31;
    endfunction

    // {busy, done, fault, dp_reset}
    function automatic logic [3:0] ref_status(input int st);
        return {st == M_RUN || st == M_RESTART, st == M_HALTED,
                st == M_FAULT,
                st == M_IDLE || st == M_RESTART || st == M_FAULT};
    endfunction

    function automatic logic [6:0] obs_ctrl();
        return {dp.s_inc, dp.s_inm, dp.we3, dp.wez, dp.ALUOp};
    endfunction

    function automatic logic [3:0] obs_status();
        return {busy, done, fault, dp.dp_reset};
    endfunction

    task automatic tick();
        int ns;
        int v;
        ns = m_st;
        v = int'(dp.opcode);
        case (m_st)
            M_IDLE: if (start) begin ns = M_RUN; m_cnt = 0; end
            M_RUN: begin
                if (!ref_legal(dp.opcode)) ns = M_FAULT;
                else if (v == 31) ns = M_HALTED;
                else if (m_cnt < 65535) m_cnt++;
            end
            M_HALTED: if (start) begin ns = M_RESTART; m_cnt = 0; end
            M_RESTART: ns = M_RUN;
            M_FAULT: if (start) begin ns = M_RUN; m_cnt = 0; end
            default: ns = M_IDLE;
        endcase
        @(posedge clk);
        m_st = ns;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dp.opcode = 6'b010011;
        dp.zero = 1'b0;
        m_st = M_IDLE;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs_status() !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_status got %b exp %b", obs_status(), 4'b0001);
        end
        n_checks++;
        if (instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count got %h exp 0", instr_count);
        end
        n_checks++;
        if (obs_ctrl() !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp %b", obs_ctrl(), 7'b1000000);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_status() !== ref_status(m_st)) begin
            n_fail++;
            $display("FAIL idle_status got %b exp %b", obs_status(), ref_status(m_st));
        end
    endtask

    task automatic test_program();
        logic [15:0] rom [0:7];
        logic [7:0]  rf [0:3];
        logic [6:0]  e;
        logic [7:0]  imm;
        logic [7:0]  res;
        int pc;
        logic z;
        bit jz_seen;
        rom[0] = {6'b000000, 2'd1, 8'd5};
        rom[1] = {6'b000100, 2'd1, 8'hFB};
        rom[2] = {6'b010001, 10'd4};
        rom[3] = {6'b010011, 10'd0};
        rom[4] = {6'b011111, 10'd4};
        for (int i = 5; i < 8; i++) rom[i] = 16'd0;
        for (int i = 0; i < 4; i++) rf[i] = 8'd0;
        pc = 0;
        z = 1'b0;
        jz_seen = 0;
        dp.opcode = rom[0][15:10];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && m_st == M_RUN; i++) begin
            dp.opcode = rom[pc][15:10];
            dp.zero = z;
            #1;
            e = ref_ctrl(m_st, dp.opcode, z);
            n_checks++;
            if (obs_ctrl() !== e) begin
                n_fail++;
                $display("FAIL prog_ctrl pc=%0d got %b exp %b", pc, obs_ctrl(), e);
            end
            if (pc == 2) begin
                jz_seen = 1;
                n_checks++;
                if (dp.s_inc !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prog_jz_sinc got %b exp 0", dp.s_inc);
                end
            end
            imm = rom[pc][7:0];
            res = (e[2:0] == 3'b010) ? rf[rom[pc][9:8]] + imm : imm;
            tick();
            if (e[4]) rf[rom[pc][9:8]] = res;
            if (e[3]) z = (res == 8'd0);
            pc = e[6] ? pc + 1 : int'(rom[pc][9:0]);
            if (pc > 7) pc = 7;
        end
        dp.opcode = rom[pc][15:10];
        #1;
        n_checks++;
        if (m_st != M_HALTED || !jz_seen) begin
            n_fail++;
            $display("FAIL prog_timeout got state %0d exp %0d", m_st, M_HALTED);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_done got %b exp 1", done);
        end
        n_checks++;
        if (instr_count !== 16'd3) begin
            n_fail++;
            $display("FAIL prog_count got %0d exp 3", instr_count);
        end
    endtask

    task automatic test_halt_restart();
        n_checks++;
        if (obs_ctrl() !== 7'b0000000) begin
            n_fail++;
            $display("FAIL halted_ctrl got %b exp %b", obs_ctrl(), 7'b0000000);
        end
        start = 1'b1;
        dp.opcode = 6'b010011;
        tick();
        n_checks++;
        if (obs_status() !== 4'b1001) begin
            n_fail++;
            $display("FAIL restart_status got %b exp %b", obs_status(), 4'b1001);
        end
        n_checks++;
        if (obs_ctrl() !== 7'b1000000) begin
            n_fail++;
            $display("FAIL restart_ctrl got %b exp %b", obs_ctrl(), 7'b1000000);
        end
        tick();
        n_checks++;
        if (obs_status() !== 4'b1000 || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_run got %b/%0d exp 1000/0", obs_status(), instr_count);
        end
        tick();
        n_checks++;
        if (obs_status() !== ref_status(m_st) || instr_count !== 16'(m_cnt)) begin
            n_fail++;
            $display("FAIL run_ignores_start got %b/%0d exp %b/%0d", obs_status(), instr_count, ref_status(m_st), m_cnt);
        end
        start = 1'b0;
    endtask

    task automatic test_jnz_alu();
        dp.opcode = 6'b010010;
        dp.zero = 1'b1;
        #1;
        n_checks++;
        if (obs_ctrl() !== 7'b1000000) begin
            n_fail++;
            $display("FAIL jnz_z1 got %b exp %b", obs_ctrl(), 7'b1000000);
        end
        dp.zero = 1'b0;
        #1;
        n_checks++;
        if (obs_ctrl() !== 7'b0000000) begin
            n_fail++;
            $display("FAIL jnz_z0 got %b exp %b", obs_ctrl(), 7'b0000000);
        end
        dp.opcode = 6'b101100;
        #1;
        n_checks++;
        if (obs_ctrl() !== 7'b1011011) begin
            n_fail++;
            $display("FAIL alu_101100 got %b exp %b", obs_ctrl(), 7'b1011011);
        end
        tick();
    endtask

    task automatic test_illegal();
        int held;
        dp.opcode = 6'b001010;
        #1;
        n_checks++;
        if (dp.we3 !== 1'b0 || dp.wez !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_writes got %b%b exp 00", dp.we3, dp.wez);
        end
        held = m_cnt;
        tick();
        n_checks++;
        if (obs_status() !== 4'b0011 || instr_count !== 16'(held)) begin
            n_fail++;
            $display("FAIL fault_status got %b/%0d exp 0011/%0d", obs_status(), instr_count, held);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        dp.opcode = 6'b010011;
        #1;
        n_checks++;
        if (obs_status() !== 4'b1000 || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL fault_restart got %b/%0d exp 1000/0", obs_status(), instr_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        logic [6:0] e;
        for (int i = 0; i < 300; i++) begin
            op = 6'($urandom_range(0, 63));
            while (!ref_legal(op) || op == 6'd31) op = 6'($urandom_range(0, 63));
            dp.opcode = op;
            dp.zero = 1'($urandom);
            start = 1'($urandom_range(0, 3) == 0);
            #1;
            e = ref_ctrl(m_st, op, dp.zero);
            n_checks++;
            if (obs_ctrl() !== e || instr_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand op=%b got %b/%0d exp %b/%0d", op, obs_ctrl(), instr_count, e, m_cnt);
            end
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (obs_status() !== ref_status(m_st)) begin
            n_fail++;
            $display("FAIL rand_status got %b exp %b", obs_status(), ref_status(m_st));
        end
    endtask

    task automatic test_saturation();
        dp.opcode = 6'b010011;
        for (int i = 0; i < 70000; i++) tick();
        n_checks++;
        if (instr_count !== 16'hFFFF || m_cnt != 65535) begin
            n_fail++;
            $display("FAIL saturation got %h exp ffff", instr_count);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_st = M_IDLE;
        m_cnt = 0;
        n_checks++;
        if (obs_status() !== 4'b0001 || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%h exp 0001/0000", obs_status(), instr_count);
        end
        n_checks++;
        if (obs_ctrl() !== 7'b1000000) begin
            n_fail++;
            $display("FAIL async_reset_ctrl got %b exp %b", obs_ctrl(), 7'b1000000);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (obs_status() !== ref_status(m_st) || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL start_after_reset got %b/%0d exp %b/0", obs_status(), instr_count, ref_status(m_st));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_program();
        test_halt_restart();
        test_jnz_alu();
        test_illegal();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
